// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
// Optional build macro used by the top: BOOTH_EARLY_TERM_EN.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Booth recoding of the current multiplier bit pair {Q[0], q_1}.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b10:   return OP_SUB;
            2'b01:   return OP_ADD;
            default: return OP_NOP;
        endcase
    endfunction

    // Extra top bit when widening an operand to WIDTH+1: sign bit or zero.
    function automatic logic ext_msb(input logic msb, input logic signed_mode);
        return msb & signed_mode;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Q, q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int W1 = 9
) (
    input  logic [W1-1:0] a,
    input  logic [W1-1:0] q,
    input  logic          q_1,
    input  logic [W1-1:0] m,
    output logic [W1-1:0] a_next,
    output logic [W1-1:0] q_next,
    output logic          q_1_next
);

    logic [W1-1:0] sum;

    always_comb begin
        sum = a;
        case (booth_decode(q[0], q_1))
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < W1 - 1; gi++) begin : g_shift
            assign a_next[gi] = sum[gi + 1];
            assign q_next[gi] = q[gi + 1];
        end
    endgenerate

    // A keeps its sign bit; A's LSB falls into the top of Q.
    assign a_next[W1-1] = sum[W1-1];
    assign q_next[W1-1] = sum[0];
    assign q_1_next     = q[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-2 Booth multiplier, one step per clock, valid/ready on both sides.
// Define BOOTH_EARLY_TERM_EN to finish in one cycle once the remaining multiplier bits are uniform.
module booth_multiplier_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   md,
    input  logic [WIDTH-1:0]   mr,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int W1    = WIDTH + 1;
    localparam int CNT_W = $clog2(WIDTH + 2);

    state_t               state_reg;
    logic [W1-1:0]        a_reg;
    logic [W1-1:0]        q_reg;
    logic                 q_1_reg;
    logic [W1-1:0]        m_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [2*WIDTH-1:0]   product_reg;
    logic                 out_valid_reg;

    logic [W1-1:0]        a_next;
    logic [W1-1:0]        q_next;
    logic                 q_1_next;
    logic [2*WIDTH-1:0]   product_next;

    booth_step #(.W1(W1)) u_step (
        .a        (a_reg),
        .q        (q_reg),
        .q_1      (q_1_reg),
        .m        (m_reg),
        .a_next   (a_next),
        .q_next   (q_next),
        .q_1_next (q_1_next)
    );

    // Low 2*WIDTH bits of {A, Q} after the final step.
    assign product_next = {a_next[WIDTH-2:0], q_next};

`ifdef BOOTH_EARLY_TERM_EN
    logic [W1-1:0]          rem_mask;
    logic                   early_term;
    logic [CNT_W-1:0]       shift_amt;
    logic signed [2*W1:0]   work_shifted;

    // After count_reg steps the unprocessed multiplier bits sit in Q[W1-1-count:0].
    assign rem_mask     = {W1{1'b1}} >> count_reg;
    assign early_term   = q_1_reg ? ((q_reg | ~rem_mask) == {W1{1'b1}})
                                  : ((q_reg & rem_mask) == '0);
    assign shift_amt    = CNT_W'(W1) - count_reg;
    assign work_shifted = $signed({a_reg, q_reg, q_1_reg}) >>> shift_amt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            q_reg         <= '0;
            q_1_reg       <= 1'b0;
            m_reg         <= '0;
            count_reg     <= '0;
            product_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= '0;
                        q_reg     <= {ext_msb(mr[WIDTH-1], signed_mode), mr};
                        q_1_reg   <= 1'b0;
                        m_reg     <= {ext_msb(md[WIDTH-1], signed_mode), md};
                        count_reg <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
`ifdef BOOTH_EARLY_TERM_EN
                    if (early_term) begin
                        {a_reg, q_reg, q_1_reg} <= work_shifted;
                        product_reg             <= work_shifted[2*WIDTH:1];
                        out_valid_reg           <= 1'b1;
                        state_reg               <= DONE;
                    end else
`endif
                    begin
                        a_reg     <= a_next;
                        q_reg     <= q_next;
                        q_1_reg   <= q_1_next;
                        count_reg <= count_reg + CNT_W'(1);
                        if (count_reg == CNT_W'(WIDTH)) begin
                            product_reg   <= product_next;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign product   = product_reg;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq: directed WIDTH=4 cases plus randomized WIDTH=8
// transactions against an integer-arithmetic reference product.
module tb_booth_multiplier_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic       in_valid4, in_ready4, sm4, out_valid4, out_ready4, busy4;
    logic [3:0] md4, mr4;
    logic [7:0] product4;

    logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
    logic [7:0]  md8, mr8;
    logic [15:0] product8;

    booth_multiplier_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .md(md4), .mr(mr4), .signed_mode(sm4), .out_valid(out_valid4),
        .out_ready(out_ready4), .product(product4), .busy(busy4)
    );

    booth_multiplier_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .md(md8), .mr(mr8), .signed_mode(sm8), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    // Reference: interpret operands per mode, multiply as integers, keep 2*w bits.
    function automatic longint ref_mul(longint a, longint b, int w, bit s);
        if (s && a[w-1]) a = a - (longint'(1) << w);
        if (s && b[w-1]) b = b - (longint'(1) << w);
        return (a * b) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Edges after the accepting edge until out_valid is seen (bounded).
    task automatic wait_valid4(output int edges);
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid4) break;
        end
    endtask

    task automatic wait_valid8(output int edges);
        edges = 0;
        while (edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid8) break;
        end
    endtask

    task automatic xact4(input logic [3:0] a, input logic [3:0] b, input bit s,
                         input logic [7:0] exp, input string name);
        int edges;
        @(negedge clk);
        md4 = a; mr4 = b; sm4 = s; in_valid4 = 1'b1; out_ready4 = 1'b0;
        vectors++;
        if (in_ready4 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept: in_ready=%b required 1", name, in_ready4);
        end
        @(posedge clk);
        #1 in_valid4 = 1'b0; md4 = ~a; mr4 = ~b; sm4 = ~s;
        wait_valid4(edges);
        vectors++;
        if (out_valid4 !== 1'b1 || product4 !== exp) begin
            miscompares++;
            $display("FAIL %s product: out_valid=%b product=%h required 1/%h",
                     name, out_valid4, product4, exp);
        end
        vectors++;
`ifdef BOOTH_EARLY_TERM_EN
        if (edges < 1 || edges > 5) begin
`else
        // 5 edges after the accepting edge = 6th edge counting the accept.
        if (edges != 5) begin
`endif
            miscompares++;
            $display("FAIL %s latency: edges=%0d required 5", name, edges);
        end
        $display("xact4 %s md=%h mr=%h s=%0d product=%h exp=%h edges=%0d",
                 name, a, b, s, product4, exp, edges);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1 out_ready4 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid4 = 1'b0; md4 = '0; mr4 = '0; sm4 = 1'b0; out_ready4 = 1'b0;
        in_valid8 = 1'b0; md8 = '0; mr8 = '0; sm8 = 1'b0; out_ready8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0 || product4 !== 8'h00 ||
            in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || product8 !== 16'h0) begin
            miscompares++;
            $display("FAIL reset: rdy=%b/%b vld=%b/%b busy=%b/%b prod=%h/%h required 1/1 0/0 0/0 0/0",
                     in_ready4, in_ready8, out_valid4, out_valid8, busy4, busy8, product4, product8);
        end
        $display("reset in_ready=%b out_valid=%b product=%h", in_ready4, out_valid4, product4);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        xact4(4'h3, 4'hE, 1'b1, 8'hFA, "3x-2");
        xact4(4'hF, 4'hF, 1'b0, 8'hE1, "15x15u");
        xact4(4'hF, 4'hF, 1'b1, 8'h01, "-1x-1");
        xact4(4'h8, 4'h8, 1'b1, 8'h40, "-8x-8");
        xact4(4'h8, 4'h7, 1'b1, 8'hC8, "-8x7");
    endtask

    task automatic test_backpressure;
        int  edges;
        bit  ok;
        ok = 1'b1;
        @(negedge clk);
        md4 = 4'h9; mr4 = 4'h6; sm4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        wait_valid4(edges);
        for (int k = 0; k < 10; k++) begin
            md4 = 4'(k); mr4 = 4'(k + 3); in_valid4 = k[0];
            if (out_valid4 !== 1'b1 || product4 !== 8'd54 || in_ready4 !== 1'b0 || busy4 !== 1'b1)
                ok = 1'b0;
            @(negedge clk);
        end
        in_valid4 = 1'b0;
        vectors++;
        if (!ok || out_valid4 !== 1'b1 || product4 !== 8'd54) begin
            miscompares++;
            $display("FAIL stall_hold: out_valid=%b product=%h in_ready=%b required 1/36/0",
                     out_valid4, product4, in_ready4);
        end
        out_ready4 = 1'b1;
        @(posedge clk);
        #1 out_ready4 = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b required 1/0", in_ready4, out_valid4);
        end
        $display("backpressure product=%h held 10 cycles", 8'd54);
        xact4(4'h2, 4'h7, 1'b0, 8'h0E, "after_stall");
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        md4 = 4'h7; mr4 = 4'h5; sm4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || product4 !== 8'h00 || busy4 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_run_reset: in_ready=%b out_valid=%b product=%h required 1/0/00",
                     in_ready4, out_valid4, product4);
        end
        $display("mid_run_reset in_ready=%b out_valid=%b product=%h", in_ready4, out_valid4, product4);
        xact4(4'h5, 4'h6, 1'b0, 8'h1E, "5x6_after_rst");
    endtask

    task automatic test_back_to_back;
        time t_acc [3];
        int  edges;
        logic [3:0] a, b;
        logic [7:0] exp;
        out_ready4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            exp = 8'(ref_mul(longint'(a), longint'(b), 4, 1'b1));
            @(negedge clk);
            md4 = a; mr4 = b; sm4 = 1'b1; in_valid4 = 1'b1;
            @(posedge clk);
            t_acc[i] = $time;
            #1 in_valid4 = 1'b0;
            wait_valid4(edges);
            vectors++;
            if (out_valid4 !== 1'b1 || product4 !== exp) begin
                miscompares++;
                $display("FAIL b2b_product[%0d]: product=%h required %h", i, product4, exp);
            end
`ifndef BOOTH_EARLY_TERM_EN
            if (i > 0) begin
                vectors++;
                if (t_acc[i] - t_acc[i-1] != 70) begin
                    miscompares++;
                    $display("FAIL b2b_period[%0d]: period=%0t required 70", i, t_acc[i] - t_acc[i-1]);
                end
            end
`endif
            $display("b2b[%0d] md=%h mr=%h product=%h exp=%h", i, a, b, product4, exp);
        end
        @(posedge clk);
        #1 out_ready4 = 1'b0;
    endtask

    task automatic test_random8(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0]  a, b;
            logic [15:0] exp;
            bit          s, ok;
            int          edges, stall;
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom_range(0, 1));
            case (i % 16)
                0: a = 8'h80;
                1: b = 8'h80;
                2: begin a = 8'h80; b = 8'h80; end
                3: b = 8'h00;
                4: b = 8'hFF;
                default: ;
            endcase
            exp = 16'(ref_mul(longint'(a), longint'(b), 8, s));
            @(negedge clk);
            md8 = a; mr8 = b; sm8 = s; in_valid8 = 1'b1; out_ready8 = 1'($urandom_range(0, 1));
            ok = (in_ready8 === 1'b1);
            @(posedge clk);
            #1 in_valid8 = 1'b0; md8 = 8'($urandom); mr8 = 8'($urandom); sm8 = ~s;
            wait_valid8(edges);
            if (out_valid8 !== 1'b1 || product8 !== exp) ok = 1'b0;
`ifdef BOOTH_EARLY_TERM_EN
            if (edges < 1 || edges > 9) ok = 1'b0;
`else
            if (edges != 9) ok = 1'b0;
`endif
            stall = $urandom_range(0, 3);
            out_ready8 = 1'b0;
            for (int k = 0; k < stall; k++) begin
                in_valid8 = 1'($urandom_range(0, 1));
                @(posedge clk);
                @(negedge clk);
                if (out_valid8 !== 1'b1 || product8 !== exp || in_ready8 !== 1'b0) ok = 1'b0;
            end
            in_valid8 = 1'b0;
            out_ready8 = 1'b1;
            @(posedge clk);
            #1 out_ready8 = 1'b0;
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL rand8[%0d]: md=%h mr=%h s=%0d product=%h edges=%0d required %h",
                         i, a, b, s, product8, edges, exp);
            end
            if (i % 500 == 0)
                $display("rand8[%0d] md=%h mr=%h s=%0d product=%h exp=%h", i, a, b, s, product8, exp);
        end
    endtask

`ifdef BOOTH_EARLY_TERM_EN
    task automatic test_early_term;
        int edges;
        @(negedge clk);
        md8 = 8'h5A; mr8 = 8'h00; sm8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        wait_valid8(edges);
        vectors++;
        if (edges != 1 || out_valid8 !== 1'b1 || product8 !== 16'h0) begin
            miscompares++;
            $display("FAIL early_mr0: edges=%0d product=%h required 1/0000", edges, product8);
        end
        $display("early_term mr=0 edges=%0d product=%h", edges, product8);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1 out_ready8 = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back;
`ifdef BOOTH_EARLY_TERM_EN
        test_early_term;
`endif
        test_random8(3000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
